rom_read_arbiter: RTL and testbench

Shares one combinational lookup ROM (9-bit address, 8-bit data, `cs`/`rd_en` enables) between two requesters. Each requester issues a burst read (start address and length). The arbiter grants requesters round-robin, sequences consecutive ROM addresses, and returns registered data beats to the owning requester. It sits between the ROM instance and its client blocks, and is the only driver of the ROM's `addr`, `cs` and `rd_en`.

---
 rtl/rom_ctrl_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 45 ++++
 rtl/rom_read_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rom_read_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_ctrl_pkg.sv
// Shared definitions for the ROM read arbiter: FSM state encoding and
// default widths of the ROM address, ROM data and burst length fields.
package rom_ctrl_pkg;

  // Default ROM address width (512-entry lookup ROM).
  localparam int DEF_ADDR_W = 9;
  // Default ROM data width.
  localparam int DEF_DATA_W = 8;
  // Default burst length field width; a burst is len+1 beats.
  localparam int DEF_LEN_W  = 4;

  // Sequencer states: IDLE = arbitration, READ = burst on the ROM.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // One-hot response select for a given owner index.
  function automatic logic [1:0] owner_onehot(input logic idx);
    logic [1:0] oh;
    if (idx) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. With a single requester the grant goes to it;
// with both requesting, the requester named by prio wins.
module rr_arb2 (
  input  logic [1:0] req_valid_i,
  input  logic       prio_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o,
  output logic       grant_any_o
);

  // Combinational grant selection from the request vector and the pointer.
  always_comb begin
    grant_o     = 2'b00;
    grant_idx_o = 1'b0;
    grant_any_o = 1'b0;
    case (req_valid_i)
      2'b01: begin
        grant_o     = 2'b01;
        grant_idx_o = 1'b0;
        grant_any_o = 1'b1;
      end
      2'b10: begin
        grant_o     = 2'b10;
        grant_idx_o = 1'b1;
        grant_any_o = 1'b1;
      end
      2'b11: begin
        grant_any_o = 1'b1;
        if (prio_i) begin
          grant_o     = 2'b10;
          grant_idx_o = 1'b1;
        end else begin
          grant_o     = 2'b01;
          grant_idx_o = 1'b0;
        end
      end
      default: begin
        grant_o     = 2'b00;
        grant_idx_o = 1'b0;
        grant_any_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one combinational lookup ROM between two burst requesters.
// Grants round-robin in IDLE, walks consecutive ROM addresses in READ and
// returns one registered data beat per cycle to the owning requester.
module rom_read_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LEN_W-1:0]  req_len,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                busy,
  output logic [ADDR_W-1:0]   rom_addr,
  output logic                rom_cs,
  output logic                rom_rd_en,
  input  logic [DATA_W-1:0]   rom_data
);

  // Sequencer state
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;

  // Response register
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;

  // Arbiter results
  logic [1:0]          grant_s;
  logic                grant_idx_s;
  logic                grant_any_s;

  rr_arb2 u_arb (
    .req_valid_i (req_valid),
    .prio_i      (prio_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .grant_any_o (grant_any_s)
  );

  // Next-state logic: accept a burst in IDLE, step address/count in READ.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    prio_d     = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d = ST_READ;
          owner_d = grant_idx_s;
          if (grant_idx_s) begin
            cur_addr_d = req_addr[ADDR_W +: ADDR_W];
            cnt_d      = req_len[LEN_W +: LEN_W];
          end else begin
            cur_addr_d = req_addr[0 +: ADDR_W];
            cnt_d      = req_len[0 +: LEN_W];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        // Address wraps naturally at 2^ADDR_W.
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == {LEN_W{1'b0}}) begin
          state_d = ST_IDLE;
          prio_d  = ~owner_q;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= {ADDR_W{1'b0}};
      cnt_q      <= {LEN_W{1'b0}};
      owner_q    <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      prio_q     <= prio_d;
    end
  end

  // Response next values: capture ROM data each READ cycle for the owner.
  always_comb begin
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    if (state_q == ST_READ) begin
      rsp_valid_d = owner_onehot(owner_q);
      rsp_data_d  = rom_data;
      rsp_last_d  = (cnt_q == {LEN_W{1'b0}});
    end else begin
      rsp_valid_d = 2'b00;
      rsp_data_d  = rsp_data_q;
      rsp_last_d  = 1'b0;
    end
  end

  // Response register; data holds its last beat between bursts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= {DATA_W{1'b0}};
      rsp_last_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  // Output decode: grant only in IDLE, ROM enabled only in READ.
  always_comb begin
    req_ready = 2'b00;
    rom_addr  = {ADDR_W{1'b0}};
    rom_cs    = 1'b0;
    rom_rd_en = 1'b0;
    busy      = 1'b0;
    if (state_q == ST_READ) begin
      rom_addr  = cur_addr_q;
      rom_cs    = 1'b1;
      rom_rd_en = 1'b1;
      busy      = 1'b1;
      req_ready = 2'b00;
    end else begin
      req_ready = grant_s;
      rom_addr  = {ADDR_W{1'b0}};
      rom_cs    = 1'b0;
      rom_rd_en = 1'b0;
      busy      = 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a ROM model data = addr[7:0]^A5.
module tb_rom_read_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [17:0] req_addr;
  logic [7:0]  req_len;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        busy;
  logic [8:0]  rom_addr;
  logic        rom_cs;
  logic        rom_rd_en;
  logic [7:0]  rom_data;

  int n_tests = 0;
  int n_fail  = 0;

  rom_read_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .rom_addr  (rom_addr),
    .rom_cs    (rom_cs),
    .rom_rd_en (rom_rd_en),
    .rom_data  (rom_data)
  );

  // ROM model
  assign rom_data = rom_addr[7:0] ^ 8'hA5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rv;
    logic [8:0] a0;
    logic [3:0] l0;
    logic [8:0] a1;
    logic [3:0] l1;
    logic [1:0] e_ready;
    logic [1:0] e_rv;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic       e_cs;
    logic [8:0] e_addr;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input int a);
    logic [8:0] aa;
    aa = 9'(a);
    return aa[7:0] ^ 8'hA5;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int beats;
    int grants;
    logic [1:0] gq[$];
    logic       own;
    int g0_cyc, first0, last0, g1_cyc, beats0, gaps;
    bit g0_seen, done;

    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = 18'd0;
    req_len   = 8'd0;

    // Table: 5 idle rows, req0 addr4 len2, req1 addr510 len3 (wrap).
    for (int i = 0; i < 5; i++)
      tbl[i] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[5]  = '{2'b01, 9'd4, 4'd2, 9'd0, 4'd0, 2'b01, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[6]  = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 9'd4};
    tbl[7]  = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b01, 8'hA1, 1'b0, 1'b1, 1'b1, 9'd5};
    tbl[8]  = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b01, 8'hA0, 1'b0, 1'b1, 1'b1, 9'd6};
    tbl[9]  = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b01, 8'hA3, 1'b1, 1'b0, 1'b0, 9'd0};
    tbl[10] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[11] = '{2'b10, 9'd0, 4'd0, 9'd510, 4'd3, 2'b10, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[12] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1, 9'd510};
    tbl[13] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b10, 8'h5B, 1'b0, 1'b1, 1'b1, 9'd511};
    tbl[14] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b10, 8'h5A, 1'b0, 1'b1, 1'b1, 9'd0};
    tbl[15] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b10, 8'hA5, 1'b0, 1'b1, 1'b1, 9'd1};
    tbl[16] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b10, 8'hA4, 1'b1, 1'b0, 1'b0, 9'd0};
    tbl[17] = '{2'b00, 9'd0, 4'd0, 9'd0, 4'd0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0};

    do_reset();

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req_valid = tbl[i].rv;
      req_addr  = {tbl[i].a1, tbl[i].a0};
      req_len   = {tbl[i].l1, tbl[i].l0};
      #1;
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rv));
      chk($sformatf("row%0d rsp_last", i),  32'(rsp_last),  32'(tbl[i].e_last));
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("row%0d rom_cs", i),    32'(rom_cs),    32'(tbl[i].e_cs));
      chk($sformatf("row%0d rom_rd_en", i), 32'(rom_rd_en), 32'(tbl[i].e_cs));
      chk($sformatf("row%0d rom_addr", i),  32'(rom_addr),  32'(tbl[i].e_addr));
      if (tbl[i].e_rv != 2'b00 || i < 5)
        chk($sformatf("row%0d rsp_data", i), 32'(rsp_data), 32'(tbl[i].e_data));
    end

    // Both requesters held continuously from reset: grants alternate 0,1,0,1.
    do_reset();
    beats  = 0;
    grants = 0;
    for (int c = 0; c < 30 && beats < 4; c++) begin
      @(negedge clk);
      req_valid = 2'b11;
      req_addr  = {9'd32, 9'd16};
      req_len   = 8'd0;
      #1;
      if (rsp_valid != 2'b00) begin
        if (gq.size() == 0) begin
          chk("alt beat without grant", 32'(rsp_valid), 32'd0);
        end else begin
          own = gq.pop_front() == 2'b10;
          chk("alt beat owner", 32'(rsp_valid), own ? 32'h2 : 32'h1);
          chk("alt beat data", 32'(rsp_data), own ? 32'h85 : 32'hB5);
          chk("alt beat last", 32'(rsp_last), 32'd1);
        end
        beats++;
      end
      if (req_ready != 2'b00) begin
        chk("alt grant order", 32'(req_ready), (grants % 2 == 0) ? 32'h1 : 32'h2);
        gq.push_back(req_ready);
        grants++;
      end
    end
    chk("alt beats seen", 32'(beats), 32'd4);
    chk("alt grants enough", 32'(grants >= 4), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Long burst from requester 0; requester 1 raises valid mid-burst.
    req_addr = {9'd200, 9'd100};
    req_len  = {4'd0, 4'd15};
    g0_cyc = -1; first0 = -1; last0 = -1; g1_cyc = -1;
    beats0 = 0; gaps = 0; g0_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      req_valid[0] = !g0_seen;
      req_valid[1] = (c >= 5) && (g1_cyc < 0);
      #1;
      if (req_ready[0]) begin
        g0_seen = 1'b1;
        g0_cyc  = c;
      end
      if (req_ready[1]) g1_cyc = c;
      if (rsp_valid == 2'b01) begin
        if (first0 < 0) first0 = c;
        chk($sformatf("long beat%0d data", beats0), 32'(rsp_data), 32'(model(100 + beats0)));
        beats0++;
        if (rsp_last) last0 = c;
      end else if (first0 >= 0 && last0 < 0) begin
        gaps++;
      end
      if (rsp_valid == 2'b10) begin
        chk("long req1 data", 32'(rsp_data), 32'h6D);
        chk("long req1 last", 32'(rsp_last), 32'd1);
        done = 1'b1;
      end
    end
    chk("long finished in time", 32'(done), 32'd1);
    chk("long beats", 32'(beats0), 32'd16);
    chk("long gaps", 32'(gaps), 32'd0);
    chk("long first beat latency", 32'(first0 - g0_cyc), 32'd2);
    chk("long last position", 32'(last0 - first0), 32'd15);
    chk("long req1 grant cycle", 32'(g1_cyc), 32'(last0));
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset pulsed during beat 2 of a len=7 burst.
    req_addr = {9'd3, 9'd8};
    req_len  = {4'd1, 4'd7};
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? 2'b01 : 2'b00;
      #1;
      if (rsp_valid == 2'b01) begin
        chk("rst burst no early last", 32'(rsp_last), 32'd0);
        chk("rst burst data", 32'(rsp_data), 32'(model(8 + beats)));
        if (beats == 2) begin
          rst = 1'b1;
          #1;
          chk("rst async rsp_valid", 32'(rsp_valid), 32'd0);
          chk("rst async rom_cs", 32'(rom_cs), 32'd0);
          chk("rst async rom_rd_en", 32'(rom_rd_en), 32'd0);
          chk("rst async rsp_last", 32'(rsp_last), 32'd0);
          chk("rst async busy", 32'(busy), 32'd0);
          chk("rst async rom_addr", 32'(rom_addr), 32'd0);
          chk("rst async rsp_data", 32'(rsp_data), 32'd0);
          done = 1'b1;
        end
        beats++;
      end
    end
    chk("rst reached beat 2", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("rst held rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst held rsp_last", 32'(rsp_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b10;
    #1;
    chk("post-rst grant", 32'(req_ready), 32'h2);
    beats = 0;
    done  = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      if (rsp_valid != 2'b00) begin
        chk("post-rst beat owner", 32'(rsp_valid), 32'h2);
        chk("post-rst beat data", 32'(rsp_data), (beats == 0) ? 32'hA6 : 32'hA1);
        chk("post-rst beat last", 32'(rsp_last), (beats == 1) ? 32'd1 : 32'd0);
        beats++;
        if (beats == 2) done = 1'b1;
      end
    end
    chk("post-rst beats", 32'(beats), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
